// File: rtl/rx_ctrl_pkg.sv
// Shared types and default sizing for the receive-FIFO read controller.
package rx_ctrl_pkg;
    localparam int DATA_W_DEF  = 8;
    localparam int LEN_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/rx_timeout_counter.sv
// Counts consecutive starved cycles; tc flags the cycle on which the
// TIMEOUT-th consecutive enabled cycle occurs.
module rx_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Terminal count is combinational so the FSM can leave on this very cycle.
    assign tc = en && (cnt == CW'(TIMEOUT - 1));

    // Consecutive-cycle counter; clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        cnt <= '0;
        else if (clear) cnt <= '0;
        else if (en)    cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/rx_fifo_rd_ctrl.sv
// Read-side burst controller for the receive FIFO: pops N bytes, streams them
// through a registered valid/ready output, aborts on FIFO starvation.
module rx_fifo_rd_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_r_data,
    output logic              fifo_r_enable,
    input  logic              req,
    input  logic [LEN_W-1:0]  req_len,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);
    state_t             state, state_n;
    logic [LEN_W-1:0]   remaining;
    logic               abort;
    logic               pop;
    logic               accept;
    logic               starve;
    logic               tc;

    assign accept        = out_valid && out_ready;
    assign starve        = (state == FETCH) && fifo_empty && (remaining != '0);
    assign fifo_r_enable = pop;
    assign busy          = (state != IDLE);

    // Starvation counter restarts whenever the FIFO shows data or we leave FETCH.
    rx_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clear ((state != FETCH) || !fifo_empty),
        .en    (starve),
        .tc    (tc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and pop decision; pop only when the output slot is free or draining now.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_n = (req_len != '0) ? FETCH : DONE;
            end
            FETCH: begin
                pop = !fifo_empty && (!out_valid || out_ready) && (remaining != '0);
                if (pop && (remaining == LEN_W'(1))) state_n = DRAIN;
                else if (tc)                         state_n = DRAIN;
            end
            DRAIN: begin
                if (!out_valid || accept) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Burst bookkeeping, output register and registered completion strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining   <= '0;
            abort       <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                remaining <= req_len;
                abort     <= 1'b0;
            end else if (pop) begin
                remaining <= remaining - LEN_W'(1);
            end else if (tc) begin
                // Bytes still owed are dropped; remaining is left as-is.
                abort <= 1'b1;
            end

            if (pop) begin
                out_data  <= fifo_r_data;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end

            done        <= (state_n == DONE);
            timeout_err <= (state_n == DONE) && (state == DRAIN) && abort;
        end
    end
endmodule

// File: tb/tb_rx_fifo_rd_ctrl.sv
// Bench for rx_fifo_rd_ctrl: behavioural FIFO + burst-level reference model.
module tb_rx_fifo_rd_ctrl;
    localparam int DATA_W  = 8;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 64;
    localparam int DEPTH   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_r_data = '0;
    logic              fifo_r_enable;
    logic              req = 1'b0;
    logic [LEN_W-1:0]  req_len = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy;
    logic              done;
    logic              timeout_err;

    rx_fifo_rd_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_r_data  (fifo_r_data),
        .fifo_r_enable(fifo_r_enable),
        .req          (req),
        .req_len      (req_len),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DATA_W-1:0] q[$];       // FIFO contents
    logic [DATA_W-1:0] rxq[$];     // bytes handed to the consumer
    logic [DATA_W-1:0] expq[$];    // bytes the burst should deliver
    int pop_cycs[$];
    int pops, done_cnt, done_cyc, r_cyc, exp_left;
    logic te_seen, exp_te, ov_seen, pop_pend, rand_rdy;
    logic prev_v, prev_r;
    logic [DATA_W-1:0] prev_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void refresh();
        fifo_empty  = (q.size() == 0);
        fifo_r_data = (q.size() != 0) ? q[0] : '0;
    endfunction

    // FIFO pop applied just after the edge on which the DUT strobed r_enable.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (pop_pend && q.size() != 0) void'(q.pop_front());
        pop_pend = 1'b0;
        refresh();
    end

    // Random consumer backpressure.
    always @(posedge clk) begin
        #2;
        if (rand_rdy) out_ready = ($urandom % 4) != 0;
    end

    // Observe on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (fifo_r_enable) begin
                chk("pop_while_empty", {31'd0, fifo_empty}, 32'd0);
                pop_pend = 1'b1;
                pops++;
                pop_cycs.push_back(cyc);
            end
            if (prev_v && !prev_r) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {24'd0, out_data}, {24'd0, prev_d});
            end
            if (out_valid) ov_seen = 1'b1;
            if (out_valid && out_ready) rxq.push_back(out_data);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                te_seen  = timeout_err;
            end
            if (timeout_err) chk("te_without_done", {31'd0, done}, 32'd1);
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model: an N-byte burst delivers the first min(N, fill) FIFO bytes in order,
    // aborts iff the FIFO cannot cover N.
    task automatic burst_start(input int len);
        int n;
        n = (len < q.size()) ? len : q.size();
        expq.delete();
        for (int i = 0; i < n; i++) expq.push_back(q[i]);
        exp_left = q.size() - n;
        exp_te   = (len > q.size());
        rxq.delete();
        pop_cycs.delete();
        pops = 0; done_cnt = 0; te_seen = 1'b0; ov_seen = 1'b0;
        step();
        req = 1'b1; req_len = LEN_W'(len); r_cyc = cyc;
        step();
        req = 1'b0;
    endtask

    task automatic burst_finish(input string tag);
        for (int i = 0; i < 400 && done_cnt == 0; i++) step();
        chk({tag, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
        repeat (3) step();
        chk({tag, "_done_once"}, done_cnt, 32'd1);
        chk({tag, "_timeout_err"}, {31'd0, te_seen}, {31'd0, exp_te});
        chk({tag, "_nbytes"}, rxq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            chk({tag, "_byte"}, {24'd0, rxq[i]}, {24'd0, expq[i]});
        chk({tag, "_fifo_left"}, q.size(), exp_left);
        chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic load(input logic [DATA_W-1:0] b);
        q.push_back(b);
        refresh();
    endtask

    initial begin
        pop_pend = 1'b0; rand_rdy = 1'b0; prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
        pops = 0; done_cnt = 0; done_cyc = 0; r_cyc = 0; exp_left = 0;
        te_seen = 1'b0; exp_te = 1'b0; ov_seen = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_r_enable}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // 1: three bytes, consumer always ready, back-to-back pops
        load(8'h00); load(8'hFF); load(8'h0F);
        burst_start(3);
        burst_finish("t1");
        chk("t1_pops", pops, 32'd3);
        for (int i = 0; i < pop_cycs.size(); i++)
            chk("t1_pop_cycle", pop_cycs[i], r_cyc + 1 + i);
        chk("t1_done_cycle", done_cyc, r_cyc + 5);

        // 2: full FIFO, consumer stalls after the first byte
        for (int i = 0; i < DEPTH; i++) load(8'hA0 + 8'(i));
        out_ready = 1'b0;
        burst_start(4);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        chk("t2_first_valid", {31'd0, out_valid}, 32'd1);
        repeat (5) step();
        chk("t2_stall_pops", pops, 32'd1);
        out_ready = 1'b1;
        burst_finish("t2");
        chk("t2_not_full", {31'd0, q.size() < DEPTH}, 32'd1);

        // 3: starvation abort
        q.delete(); refresh();
        load(8'h5A); load(8'hC3);
        burst_start(5);
        burst_finish("t3");
        chk("t3_pops", pops, 32'd2);
        if (pop_cycs.size() == 2)
            chk("t3_done_cycle", done_cyc, pop_cycs[1] + TIMEOUT + 2);

        // 4: zero-length burst
        load(8'h11);
        burst_start(0);
        burst_finish("t4");
        chk("t4_pops", pops, 32'd0);
        chk("t4_done_cycle", done_cyc, r_cyc + 1);
        chk("t4_no_valid", {31'd0, ov_seen}, 32'd0);

        // 5: second req while busy is ignored
        q.delete(); refresh();
        for (int i = 0; i < 6; i++) load(8'h30 + 8'(i));
        burst_start(3);
        req = 1'b1; req_len = 8'd7;
        step();
        req = 1'b0;
        burst_finish("t5");

        // 6: async reset with a byte pending, then a 1-byte burst
        out_ready = 1'b0;
        burst_start(3);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        chk("t6_pending", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_data", {24'd0, out_data}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_done", {31'd0, done | timeout_err}, 32'd0);
        chk("t6_rst_rd_en", {31'd0, fifo_r_enable}, 32'd0);
        step(); step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        burst_start(1);
        burst_finish("t6");

        // Random bursts under random backpressure
        for (int it = 0; it < 12; it++) begin
            int fill, len;
            q.delete(); refresh();
            fill = $urandom_range(0, DEPTH);
            len  = $urandom_range(0, 10);
            for (int i = 0; i < fill; i++) load(8'($urandom));
            rand_rdy = 1'b1;
            burst_start(len);
            burst_finish("rnd");
            rand_rdy = 1'b0;
            step();
            out_ready = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
